adpll_grid_sequencer: RTL and testbench

Parametrised control plane for a ROWS x COLS network of ring-oscillator ADPLL nodes. It generalises the fixed 2x2 switch-driven setup:
- per-node neighbour weights and reference routing are derived from a mode select and grid position;
- kp/ki and reference-oscillator settings are held in registers;
- nodes are brought up by a staggered enable sequencer;
- per-node lock is monitored from the phase-error buses.

It sits between the board-level switch/config logic and the array of network ADPLL instances.

---
 rtl/adpll_grid_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_adpll_grid_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_grid_sequencer.sv
// Control plane for a ROWS x COLS ring-oscillator ADPLL grid:
// weight/ref routing, gain registers, staggered bring-up, lock monitor.
module adpll_grid_sequencer #(
  parameter int ROWS           = 2,
  parameter int COLS           = 2,
  parameter int PDET_WIDTH     = 6,
  parameter int STAGGER_CYCLES = 1024,
  parameter int LOCK_THRESH    = 2,
  parameter int LOCK_CYCLES    = 4096
) (
  input  logic                       fpga_clk_i,
  input  logic                       reset_n_i,
  input  logic                       enable_i,
  input  logic [1:0]                 mode_i,
  input  logic                       cfg_wr_i,
  input  logic                       cfg_sel_i,
  input  logic [11:0]                cfg_data_i,
  input  logic [ROWS*COLS*PDET_WIDTH-1:0] error_i,
  output logic [ROWS*COLS-1:0]       node_enable_o,
  output logic [ROWS*COLS*4-1:0]     weight_left_o,
  output logic [ROWS*COLS*4-1:0]     weight_above_o,
  output logic [ROWS*COLS*4-1:0]     weight_right_o,
  output logic [ROWS*COLS*4-1:0]     weight_below_o,
  output logic [ROWS*COLS*2-1:0]     ref_left_sel_o,
  output logic [ROWS*COLS*2-1:0]     ref_above_sel_o,
  output logic [7:0]                 kp_o,
  output logic [9:0]                 ki_o,
  output logic [11:0]                ref_k_o,
  output logic [ROWS*COLS-1:0]       lock_o,
  output logic                       all_locked_o,
  output logic [1:0]                 state_o
);

  localparam int N        = ROWS * COLS;
  localparam int W        = PDET_WIDTH;
  localparam int RAMP_LEN = N * STAGGER_CYCLES;
  localparam int CW       = $clog2(RAMP_LEN + 1);
  localparam int LW       = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RAMP    = 2'b01,
    S_RUN     = 2'b10,
    S_RESTART = 2'b11
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [CW-1:0]   ramp_cnt;
  logic [CW-1:0]   ramp_nxt;
  logic [N-1:0]    en_ramp;
  logic [N*LW-1:0] lock_cnt;
  logic [N*LW-1:0] cnt_nxt;
  logic [N-1:0]    lock_nxt;
  logic [N*4-1:0]  wl_c, wa_c, wr_c, wb_c;
  logic [N*2-1:0]  sl_c, sa_c;

  assign state_o = state;

  // Packs {left, above, right, below, left_sel, above_sel} for one node
  function automatic logic [19:0] node_cfg(
    input int r,
    input int c,
    input logic [1:0] m
  );
    logic [3:0] wl, wa, wr, wb;
    logic [1:0] sl, sa;
    logic       hr, hb;
    wl = '0;
    wa = '0;
    wr = '0;
    wb = '0;
    sl = '0;
    sa = '0;
    hr = (c < COLS - 1);
    hb = (r < ROWS - 1);
    if (m == 2'b01 || m == 2'b10) begin
      if (r == 0 && c == 0) begin
        wl = 4'd4;
        sa = 2'b10;
      end else if (r == 0) begin
        wl = 4'd4;
        sl = 2'b01;
        sa = 2'b10;
      end else if (c == 0) begin
        wa = 4'd4;
        sl = 2'b10;
        sa = 2'b01;
      end else begin
        wl = 4'd2;
        wa = 4'd2;
        sl = 2'b01;
        sa = 2'b01;
      end
      if (m == 2'b10 && (hr || hb)) begin
        wl = wl >> 1;
        wa = wa >> 1;
        wr = hr ? (hb ? 4'd1 : 4'd2) : 4'd0;
        wb = hb ? (hr ? 4'd1 : 4'd2) : 4'd0;
      end
    end else begin
      wl = 4'd4;
    end
    return {wl, wa, wr, wb, sl, sa};
  endfunction

  always_comb begin
    logic [19:0] nc;
    wl_c = '0;
    wa_c = '0;
    wr_c = '0;
    wb_c = '0;
    sl_c = '0;
    sa_c = '0;
    nc   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        nc = node_cfg(r, c, mode_i);
        wl_c[(r*COLS+c)*4 +: 4] = nc[19:16];
        wa_c[(r*COLS+c)*4 +: 4] = nc[15:12];
        wr_c[(r*COLS+c)*4 +: 4] = nc[11:8];
        wb_c[(r*COLS+c)*4 +: 4] = nc[7:4];
        sl_c[(r*COLS+c)*2 +: 2] = nc[3:2];
        sa_c[(r*COLS+c)*2 +: 2] = nc[1:0];
      end
    end
  end

  always_comb begin
    ramp_nxt = ramp_cnt + 1'b1;
    en_ramp  = '0;
    for (int k = 0; k < N; k++) begin
      en_ramp[k] = (32'(ramp_nxt) >= k * STAGGER_CYCLES);
    end
  end

  // The most negative code is excluded explicitly: its magnitude is not
  // representable as a positive W-bit value.
  always_comb begin
    logic [W-1:0]  e;
    logic [W-1:0]  mag;
    logic [LW-1:0] cur;
    logic          ok;
    cnt_nxt  = '0;
    lock_nxt = '0;
    e        = '0;
    mag      = '0;
    cur      = '0;
    ok       = 1'b0;
    for (int i = 0; i < N; i++) begin
      e   = error_i[i*W +: W];
      mag = e[W-1] ? (~e + 1'b1) : e;
      ok  = (e != {1'b1, {(W-1){1'b0}}})
            && (32'(mag) <= LOCK_THRESH);
      cur = lock_cnt[i*LW +: LW];
      if (!ok)
        cnt_nxt[i*LW +: LW] = '0;
      else if (cur == LW'(LOCK_CYCLES))
        cnt_nxt[i*LW +: LW] = cur;
      else
        cnt_nxt[i*LW +: LW] = cur + 1'b1;
      lock_nxt[i] = (cnt_nxt[i*LW +: LW] == LW'(LOCK_CYCLES));
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state           <= S_IDLE;
      mode_q          <= 2'b00;
      ramp_cnt        <= '0;
      lock_cnt        <= '0;
      node_enable_o   <= '0;
      weight_left_o   <= '0;
      weight_above_o  <= '0;
      weight_right_o  <= '0;
      weight_below_o  <= '0;
      ref_left_sel_o  <= '0;
      ref_above_sel_o <= '0;
      lock_o          <= '0;
      all_locked_o    <= 1'b0;
      kp_o            <= 8'd1;
      ki_o            <= 10'd1;
      ref_k_o         <= 12'd21;
    end else begin
      if (cfg_wr_i) begin
        if (cfg_sel_i) begin
          ref_k_o <= cfg_data_i;
        end else begin
          kp_o <= {4'b0, cfg_data_i[11:8]};
          ki_o <= {6'b0, cfg_data_i[3:0]};
        end
      end
      if (!enable_i) begin
        state           <= S_IDLE;
        ramp_cnt        <= '0;
        lock_cnt        <= '0;
        node_enable_o   <= '0;
        weight_left_o   <= '0;
        weight_above_o  <= '0;
        weight_right_o  <= '0;
        weight_below_o  <= '0;
        ref_left_sel_o  <= '0;
        ref_above_sel_o <= '0;
        lock_o          <= '0;
        all_locked_o    <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_RESTART: begin
            state           <= S_RAMP;
            mode_q          <= mode_i;
            ramp_cnt        <= '0;
            lock_cnt        <= '0;
            node_enable_o   <= N'(1);
            weight_left_o   <= wl_c;
            weight_above_o  <= wa_c;
            weight_right_o  <= wr_c;
            weight_below_o  <= wb_c;
            ref_left_sel_o  <= sl_c;
            ref_above_sel_o <= sa_c;
            lock_o          <= '0;
            all_locked_o    <= 1'b0;
          end
          S_RAMP, S_RUN: begin
            if (mode_i != mode_q) begin
              state         <= S_RESTART;
              ramp_cnt      <= '0;
              lock_cnt      <= '0;
              node_enable_o <= '0;
              lock_o        <= '0;
              all_locked_o  <= 1'b0;
            end else if (state == S_RAMP) begin
              ramp_cnt      <= ramp_nxt;
              node_enable_o <= en_ramp;
              if (32'(ramp_nxt) == RAMP_LEN)
                state <= S_RUN;
            end else begin
              node_enable_o <= '1;
              lock_cnt      <= cnt_nxt;
              lock_o        <= lock_nxt;
              all_locked_o  <= &lock_nxt;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_grid_sequencer.sv
// Bench for adpll_grid_sequencer on a 2x2 grid with short
// stagger and lock windows.
module tb_adpll_grid_sequencer;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int N    = ROWS * COLS;
  localparam int PW   = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic          cfg_wr;
  logic          cfg_sel;
  logic [11:0]   cfg_data;
  logic [N*PW-1:0] error;
  logic [N-1:0]  node_en;
  logic [N*4-1:0] wl, wa, wr, wb;
  logic [N*2-1:0] sl, sa;
  logic [7:0]    kp;
  logic [9:0]    ki;
  logic [11:0]   ref_k;
  logic [N-1:0]  lock;
  logic          all_locked;
  logic [1:0]    state;

  adpll_grid_sequencer #(
    .ROWS(ROWS),
    .COLS(COLS),
    .PDET_WIDTH(PW),
    .STAGGER_CYCLES(4),
    .LOCK_THRESH(2),
    .LOCK_CYCLES(8)
  ) dut (
    .fpga_clk_i(clk),
    .reset_n_i(rst_n),
    .enable_i(enable),
    .mode_i(mode),
    .cfg_wr_i(cfg_wr),
    .cfg_sel_i(cfg_sel),
    .cfg_data_i(cfg_data),
    .error_i(error),
    .node_enable_o(node_en),
    .weight_left_o(wl),
    .weight_above_o(wa),
    .weight_right_o(wr),
    .weight_below_o(wb),
    .ref_left_sel_o(sl),
    .ref_above_sel_o(sa),
    .kp_o(kp),
    .ki_o(ki),
    .ref_k_o(ref_k),
    .lock_o(lock),
    .all_locked_o(all_locked),
    .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [11:0] data;
    logic [7:0]  kp;
    logic [9:0]  ki;
    logic [11:0] rk;
  } cfg_vec_t;

  typedef struct {
    logic [N-1:0] en;
    logic [1:0]   st;
  } seq_t;

  cfg_vec_t   cvec [4];
  cfg_vec_t   cfg_sb [$];
  seq_t       seq_sb [$];
  logic [19:0] bi_exp  [4];
  logic [19:0] uni_exp [4];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_weights(input bit uni);
    logic [19:0] a;
    for (int i = 0; i < N; i++) begin
      a = {wl[i*4 +: 4], wa[i*4 +: 4], wr[i*4 +: 4], wb[i*4 +: 4],
           sl[i*2 +: 2], sa[i*2 +: 2]};
      chk($sformatf("%s_node%0d", uni ? "uni" : "bi", i), 32'(a),
          32'(uni ? uni_exp[i] : bi_exp[i]));
    end
  endtask

  task automatic set_err(input logic [PW-1:0] e0, input logic [PW-1:0] e1,
                         input logic [PW-1:0] e2, input logic [PW-1:0] e3);
    error = {e3, e2, e1, e0};
  endtask

  initial begin
    cfg_vec_t c;
    seq_t     s;

    cvec[0] = '{1'b0, 12'h305, 8'd3,  10'd5, 12'd21};
    cvec[1] = '{1'b1, 12'h0A0, 8'd3,  10'd5, 12'd160};
    cvec[2] = '{1'b0, 12'hFA7, 8'd15, 10'd7, 12'd160};
    cvec[3] = '{1'b1, 12'hFFF, 8'd15, 10'd7, 12'd4095};

    // {L, A, R, B, left_sel, above_sel}
    bi_exp[0]  = {4'd2, 4'd0, 4'd1, 4'd1, 2'b00, 2'b10};
    bi_exp[1]  = {4'd2, 4'd0, 4'd0, 4'd2, 2'b01, 2'b10};
    bi_exp[2]  = {4'd0, 4'd2, 4'd2, 4'd0, 2'b10, 2'b01};
    bi_exp[3]  = {4'd2, 4'd2, 4'd0, 4'd0, 2'b01, 2'b01};
    uni_exp[0] = {4'd4, 4'd0, 4'd0, 4'd0, 2'b00, 2'b10};
    uni_exp[1] = {4'd4, 4'd0, 4'd0, 4'd0, 2'b01, 2'b10};
    uni_exp[2] = {4'd0, 4'd4, 4'd0, 4'd0, 2'b10, 2'b01};
    uni_exp[3] = {4'd2, 4'd2, 4'd0, 4'd0, 2'b01, 2'b01};

    rst_n    = 1'b0;
    enable   = 1'b0;
    mode     = 2'b00;
    cfg_wr   = 1'b0;
    cfg_sel  = 1'b0;
    cfg_data = '0;
    error    = '0;
    repeat (3) tick();

    chk("rst_kp", 32'(kp), 32'd1);
    chk("rst_ki", 32'(ki), 32'd1);
    chk("rst_refk", 32'(ref_k), 32'd21);
    chk("rst_en", 32'(node_en), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wl", 32'(wl), 32'd0);
    chk("rst_sl", 32'(sl), 32'd0);
    chk("rst_lock", 32'({all_locked, lock}), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    for (int v = 0; v < 4; v++) begin
      cfg_wr   = 1'b1;
      cfg_sel  = cvec[v].sel;
      cfg_data = cvec[v].data;
      cfg_sb.push_back(cvec[v]);
      tick();
      cfg_wr = 1'b0;
      c = cfg_sb.pop_front();
      chk($sformatf("cfg%0d_kp", v), 32'(kp), 32'(c.kp));
      chk($sformatf("cfg%0d_ki", v), 32'(ki), 32'(c.ki));
      chk($sformatf("cfg%0d_refk", v), 32'(ref_k), 32'(c.rk));
    end

    mode   = 2'b10;
    enable = 1'b1;
    set_err(6'd0, 6'd2, 6'h3E, 6'd1);
    tick();
    chk_weights(1'b0);
    for (int j = 1; j <= 17; j++) begin
      if (j > 1) tick();
      for (int k = 0; k < N; k++) s.en[k] = (j >= 1 + 4 * k);
      s.st = (j >= 17) ? 2'b10 : 2'b01;
      seq_sb.push_back(s);
      s = seq_sb.pop_front();
      chk($sformatf("ramp_en_%0d", j), 32'(node_en), 32'(s.en));
      chk($sformatf("ramp_st_%0d", j), 32'(state), 32'(s.st));
    end

    repeat (7) tick();
    chk("lock_early", 32'({all_locked, lock}), 32'h00);
    tick();
    chk("lock_all", 32'({all_locked, lock}), 32'h1F);

    set_err(6'd0, 6'd2, 6'h20, 6'd1);
    tick();
    chk("lock_drop", 32'({all_locked, lock}), 32'h0B);
    set_err(6'd0, 6'd2, 6'h3D, 6'd1);
    tick();
    chk("lock_thresh3", 32'({all_locked, lock}), 32'h0B);

    mode = 2'b01;
    tick();
    chk("restart_st", 32'(state), 32'd3);
    chk("restart_en", 32'(node_en), 32'd0);
    chk("restart_lock", 32'({all_locked, lock}), 32'd0);
    tick();
    chk("reramp_st", 32'(state), 32'd1);
    chk("reramp_en", 32'(node_en), 32'd1);
    chk_weights(1'b1);

    cfg_wr   = 1'b1;
    cfg_sel  = 1'b0;
    cfg_data = 12'hC03;
    tick();
    cfg_wr = 1'b0;
    chk("cfg_ramp_kp", 32'(kp), 32'd12);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_st", 32'(state), 32'd0);
    chk("midrst_en", 32'(node_en), 32'd0);
    chk("midrst_kp", 32'(kp), 32'd1);
    chk("midrst_ki", 32'(ki), 32'd1);
    chk("midrst_refk", 32'(ref_k), 32'd21);
    chk("midrst_w", 32'({wl, wa}), 32'd0);

    tick();
    chk("ramp2_st", 32'(state), 32'd1);
    enable = 1'b0;
    mode   = 2'b10;
    tick();
    chk("idle_wins_st", 32'(state), 32'd0);
    chk("idle_wins_en", 32'(node_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
